// File: rtl/aes_key_word_unit.sv
// AES key-expansion word generator for an EX-stage functional unit.
// Produces w[i] = w[i-Nk] ^ temp, running SubWord one byte per clock through a single S-box.
module aes_key_word_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        valid_in,
    input  logic [1:0]  key_size_in,
    input  logic [5:0]  word_idx_in,
    input  logic [31:0] w_prev_in,
    input  logic [31:0] w_back_in,
    output logic        stall_out,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, SUBST, FIN} state_t;

    // Row r holds S-box entries 16r..16r+15, entry 16r+0 in the top byte.
    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon_f(input logic [5:0] n);
        case (n)
            6'd1:    rcon_f = 8'h01;
            6'd2:    rcon_f = 8'h02;
            6'd3:    rcon_f = 8'h04;
            6'd4:    rcon_f = 8'h08;
            6'd5:    rcon_f = 8'h10;
            6'd6:    rcon_f = 8'h20;
            6'd7:    rcon_f = 8'h40;
            6'd8:    rcon_f = 8'h80;
            6'd9:    rcon_f = 8'h1b;
            6'd10:   rcon_f = 8'h36;
            default: rcon_f = 8'h00;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] back_q, back_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;

    logic [5:0]   idx_mod, idx_div;
    logic         is_rot, is_sub;
    logic [7:0]   sbox_in, sbox_out;
    logic [127:0] sbox_row;

    // Nk = 4/6/8; key_size 11 decodes as AES-128.
    always_comb begin
        case (key_size_in)
            2'b01: begin
                idx_mod = word_idx_in % 6'd6;
                idx_div = word_idx_in / 6'd6;
            end
            2'b10: begin
                idx_mod = {3'b000, word_idx_in[2:0]};
                idx_div = {3'b000, word_idx_in[5:3]};
            end
            default: begin
                idx_mod = {4'b0000, word_idx_in[1:0]};
                idx_div = {2'b00, word_idx_in[5:2]};
            end
        endcase
        is_rot = (idx_mod == 6'd0);
        is_sub = (key_size_in == 2'b10) && (idx_mod == 6'd4);
    end

    always_comb begin
        case (cnt_q)
            2'd0:    sbox_in = word_q[31:24];
            2'd1:    sbox_in = word_q[23:16];
            2'd2:    sbox_in = word_q[15:8];
            default: sbox_in = word_q[7:0];
        endcase
        sbox_row = SBOX_ROWS[sbox_in[7:4]];
        sbox_out = sbox_row[{~sbox_in[3:0], 3'b000} +: 8];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        word_d   = word_q;
        back_d   = back_q;
        rcon_d   = rcon_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
            cnt_d   = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    // The instruction still in EX during the done cycle was already executed.
                    if (valid_in && !done_q) begin
                        word_d  = is_rot ? {w_prev_in[23:0], w_prev_in[31:24]} : w_prev_in;
                        back_d  = w_back_in;
                        rcon_d  = is_rot ? rcon_f(idx_div) : 8'h00;
                        cnt_d   = 2'd0;
                        state_d = (is_rot || is_sub) ? SUBST : FIN;
                    end
                end
                SUBST: begin
                    case (cnt_q)
                        2'd0:    word_d[31:24] = sbox_out;
                        2'd1:    word_d[23:16] = sbox_out;
                        2'd2:    word_d[15:8]  = sbox_out;
                        default: word_d[7:0]   = sbox_out;
                    endcase
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = FIN;
                    end
                end
                FIN: begin
                    result_d = back_q ^ word_q ^ {rcon_q, 24'h000000};
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            word_q   <= 32'h0;
            back_q   <= 32'h0;
            rcon_q   <= 8'h00;
            done_q   <= 1'b0;
            result_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            word_q   <= word_d;
            back_q   <= back_d;
            rcon_q   <= rcon_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign stall_out = valid_in && !done_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: doc/aes_key_word_unit.md
AES_KEY_WORD_UNIT -- requirements
Module: aes_key_word_unit

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (all state updates on rising edge); reset input 1 (synchronous, active-high).
REQ-002 flush  input  1  synchronous abort of the in-flight operation (EX-stage flush).
REQ-003 valid_in  input  1  AES key-word instruction present in EX (enable_AES from ID/EX register).
REQ-004 key_size_in  input  2  00=AES-128 (Nk=4), 01=AES-192 (Nk=6), 10=AES-256 (Nk=8), 11 treated as 00.
REQ-005 word_idx_in  input  6  index i of key-schedule word to generate.
REQ-006 w_prev_in  input  32  w[i-1].
REQ-007 w_back_in  input  32  w[i-Nk].
REQ-008 stall_out  output  1  combinational hold request to PC/IF-ID/ID-EX registers.
REQ-009 done  output  1  one-cycle pulse: result valid.
REQ-010 result  output  32  generated word w[i].

Function
REQ-011 Byte order SHALL be big-endian: byte0 = bits[31:24], byte3 = bits[7:0].
REQ-012 Mode SHALL be decoded at accept: ROT (i mod Nk == 0): temp = SubWord(RotWord(w_prev)) XOR {Rcon,24'h0}; SUB (Nk==8 and i mod 8 == 4): temp = SubWord(w_prev); otherwise XOR: temp = w_prev.
REQ-013 RotWord SHALL rotate left by 8 bits: {b1,b2,b3,b0}.
REQ-014 Rcon SHALL be indexed by i/Nk (integer division): 1..10 -> 01,02,04,08,10,20,40,80,1B,36; any other index -> 00.
REQ-015 result SHALL equal w_back XOR temp, computed on values captured at accept.
REQ-016 SubWord SHALL use one internal 256-entry FIPS-197 S-box, one byte per clock, byte0 first.
REQ-017 States SHALL be IDLE, SUBST, FIN; accept = valid_in && state==IDLE && !done && !flush.
REQ-018 On accept, the unit SHALL capture all inputs, then: XOR mode -> FIN; ROT/SUB -> SUBST with byte counter 0.
REQ-019 SUBST SHALL substitute byte[counter] each clock; after counter 3 -> FIN.
REQ-020 FIN SHALL register result, assert done for exactly one cycle, and -> IDLE.
REQ-021 Latency (accept edge to done-high cycle) SHALL be 1 clock for XOR mode and 5 clocks for ROT/SUB modes.
REQ-022 stall_out SHALL equal valid_in && !done in all states; it is low in the done cycle so the pipeline advances exactly once.
REQ-023 A valid_in seen while done is high SHALL NOT be accepted (no double-execution of the held instruction).
REQ-024 result SHALL hold its value until the next FIN; input changes while not IDLE SHALL be ignored.
REQ-025 flush SHALL have priority over all other activity: -> IDLE, counter 0, done 0, result unchanged, no done generated for the aborted operation.
REQ-026 word_idx_in values outside the valid schedule range SHALL still produce the REQ-012..015 result without error signalling.

Reset
REQ-027 reset SHALL force state IDLE, byte counter 0, done 0, result 32'h0, and all captured operands 0; it overrides flush and valid_in.
REQ-028 reset asserted mid-operation SHALL abort with no done pulse; the first accept is possible on the first clock after reset deasserts.

Verification
REQ-029 AES-128, i=4, w_prev=09cf4f3c, w_back=2b7e1516 -> done 5 clocks after accept, result a0fafe17; stall_out high through accept and SUBST/FIN cycles, low in the done cycle.
REQ-030 AES-128, i=5, w_prev=a0fafe17, w_back=28aed2a6 -> done 1 clock after accept, result 88542cb1.
REQ-031 AES-256, i=12, w_prev=2067fcde, w_back=1f352c07 -> SUB mode (no Rcon), result a8b09c1a after 5 clocks.
REQ-032 valid_in held high through the done cycle and one cycle beyond -> exactly one done pulse per operation.
REQ-033 flush asserted at byte counter 2 -> IDLE next clock, no done, result retains the previous value; a new accept next cycle completes normally.
REQ-034 reset asserted in SUBST -> done 0, result 00000000; key_size_in=11 with i=4 vectors of REQ-029 -> result a0fafe17.
